// File: rtl/ddr_wr_packer_if.sv
// Bundles the input word stream and the DDR write command/data channels.
// The master modport is the packer's view; the slave modport is the
// environment's view (word source plus DDR controller).
interface ddr_wr_packer_if #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 256,
    parameter int ADDR_WIDTH = 28
);
    logic                    in_valid;
    logic [IN_WIDTH-1:0]     in_data;
    logic                    in_last;
    logic                    in_ready;

    logic                    wr_cmd_valid;
    logic [ADDR_WIDTH-1:0]   wr_cmd_addr;
    logic [6:0]              wr_cmd_len;
    logic                    wr_cmd_ready;

    logic                    wr_data_valid;
    logic [OUT_WIDTH-1:0]    wr_data;
    logic [OUT_WIDTH/8-1:0]  wr_data_mask;
    logic                    wr_data_last;
    logic                    wr_data_ready;

    modport master (
        input  in_valid, in_data, in_last, wr_cmd_ready, wr_data_ready,
        output in_ready, wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
               wr_data_valid, wr_data, wr_data_mask, wr_data_last
    );

    modport slave (
        output in_valid, in_data, in_last, wr_cmd_ready, wr_data_ready,
        input  in_ready, wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
               wr_data_valid, wr_data, wr_data_mask, wr_data_last
    );
endinterface

// File: rtl/ddr_wr_packer.sv
// Packs 32-bit words LSB-first into 256-bit DDR beats, buffers the beats and
// issues fixed-length write bursts at incrementing addresses inside a
// circular frame region. Frame end flushes partial beats/bursts with masking.
module ddr_wr_packer #(
    parameter int                    IN_WIDTH        = 32,
    parameter int                    OUT_WIDTH       = 256,
    parameter int                    BURST_LEN       = 16,
    parameter int                    BUF_DEPTH_WIDTH = 6,
    parameter int                    ADDR_WIDTH      = 28,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    FRAME_BEATS     = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ddr_wr_packer_if.master          bus,
    output logic                     frame_done,
    output logic [BUF_DEPTH_WIDTH:0] buf_level
);
    localparam int LANES      = OUT_WIDTH / IN_WIDTH;
    localparam int LANE_BYTES = IN_WIDTH / 8;
    localparam int MASK_W     = OUT_WIDTH / 8;
    localparam int IDX_W      = $clog2(LANES);
    localparam int DEPTH      = 1 << BUF_DEPTH_WIDTH;
    localparam int BEAT_SHIFT = $clog2(OUT_WIDTH / 8);
    localparam int FCW        = $clog2(FRAME_BEATS + 1) + 1;

    localparam logic [BUF_DEPTH_WIDTH:0]   LVL_ONE   = (BUF_DEPTH_WIDTH+1)'(1);
    localparam logic [BUF_DEPTH_WIDTH:0]   LVL_BURST = (BUF_DEPTH_WIDTH+1)'(BURST_LEN);
    localparam logic [BUF_DEPTH_WIDTH-1:0] PTR_ONE   = BUF_DEPTH_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                    state;
    logic [IDX_W-1:0]          pack_idx;
    logic [OUT_WIDTH-1:0]      pack_data;
    logic [OUT_WIDTH-1:0]      beat_data;
    logic [MASK_W-1:0]         beat_mask;
    logic [OUT_WIDTH-1:0]      mem_data [DEPTH];
    logic [MASK_W-1:0]         mem_mask [DEPTH];
    logic [BUF_DEPTH_WIDTH-1:0] wr_ptr;
    logic [BUF_DEPTH_WIDTH-1:0] rd_ptr;
    logic                      ready_en;
    logic                      flush_pending;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [6:0]                beat_cnt;
    logic [FCW-1:0]            frame_cnt;

    // ready_en keeps in_ready low while reset is held; the buffer is full
    // when the level's top bit is set, and a pending flush blocks the next frame.
    assign bus.in_ready = ready_en & ~buf_level[BUF_DEPTH_WIDTH] & ~flush_pending;
    assign accept       = bus.in_valid & bus.in_ready;
    assign push         = accept & ((pack_idx == IDX_W'(LANES - 1)) | bus.in_last);
    assign pop          = bus.wr_data_valid & bus.wr_data_ready;

    // Buffer head is shown first-word-fall-through, zero whenever no beat is offered.
    assign bus.wr_data      = bus.wr_data_valid ? mem_data[rd_ptr] : '0;
    assign bus.wr_data_mask = bus.wr_data_valid ? mem_mask[rd_ptr] : '0;

    // Beat as it would look with the current word dropped into its lane; lanes above it are unused.
    always_comb begin
        beat_data = pack_data;
        beat_data[pack_idx*IN_WIDTH +: IN_WIDTH] = bus.in_data;
        beat_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            if (IDX_W'(l) > pack_idx) begin
                beat_mask[l*LANE_BYTES +: LANE_BYTES] = '1;
            end
        end
    end

    // Word packer: collects lanes and clears itself after each pushed beat so padding stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_idx  <= '0;
            pack_data <= '0;
        end else if (accept) begin
            if (push) begin
                pack_idx  <= '0;
                pack_data <= '0;
            end else begin
                pack_idx  <= pack_idx + IDX_W'(1);
                pack_data <= beat_data;
            end
        end
    end

    // Beat storage is left without reset so it can map onto RAM; pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= beat_data;
            mem_mask[wr_ptr] <= beat_mask;
        end
    end

    // Buffer pointers and occupancy; a simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   buf_level <= buf_level + LVL_ONE;
                2'b01:   buf_level <= buf_level - LVL_ONE;
                default: buf_level <= buf_level;
            endcase
        end
    end

    // Goes high on the first clock after reset release to open the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Burst sequencer: decides burst lengths, drives both DDR channels and tracks frame address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            bus.wr_cmd_valid  <= 1'b0;
            bus.wr_cmd_addr   <= '0;
            bus.wr_cmd_len    <= '0;
            bus.wr_data_valid <= 1'b0;
            bus.wr_data_last  <= 1'b0;
            beat_cnt          <= '0;
            addr              <= BASE_ADDR;
            frame_cnt         <= '0;
            flush_pending     <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept && bus.in_last) begin
                flush_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (buf_level >= LVL_BURST) begin
                        bus.wr_cmd_valid <= 1'b1;
                        bus.wr_cmd_addr  <= addr;
                        bus.wr_cmd_len   <= 7'(BURST_LEN);
                        state            <= CMD;
                    end else if (flush_pending && buf_level != '0) begin
                        bus.wr_cmd_valid <= 1'b1;
                        bus.wr_cmd_addr  <= addr;
                        bus.wr_cmd_len   <= 7'(buf_level);
                        state            <= CMD;
                    end else if (flush_pending) begin
                        frame_done    <= 1'b1;
                        addr          <= BASE_ADDR;
                        frame_cnt     <= '0;
                        flush_pending <= 1'b0;
                    end
                end
                CMD: begin
                    if (bus.wr_cmd_ready) begin
                        bus.wr_cmd_valid  <= 1'b0;
                        bus.wr_data_valid <= 1'b1;
                        bus.wr_data_last  <= (bus.wr_cmd_len == 7'd1);
                        beat_cnt          <= '0;
                        state             <= DATA;
                    end
                end
                DATA: begin
                    if (pop) begin
                        if (beat_cnt + 7'd1 == bus.wr_cmd_len) begin
                            bus.wr_data_valid <= 1'b0;
                            bus.wr_data_last  <= 1'b0;
                            state             <= IDLE;
                            if (frame_cnt + FCW'(bus.wr_cmd_len) >= FCW'(FRAME_BEATS)) begin
                                addr      <= BASE_ADDR;
                                frame_cnt <= '0;
                            end else begin
                                addr      <= addr + (ADDR_WIDTH'(bus.wr_cmd_len) << BEAT_SHIFT);
                                frame_cnt <= frame_cnt + FCW'(bus.wr_cmd_len);
                            end
                        end else begin
                            beat_cnt         <= beat_cnt + 7'd1;
                            bus.wr_data_last <= (beat_cnt + 7'd2 == bus.wr_cmd_len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_wr_packer.sv
// Randomized bench for ddr_wr_packer. Words are fed from a queue; a frame-level
// reference model turns them into expected beats and burst commands, which a
// monitor compares against the DDR channels in order.
`timescale 1ns/1ps
module tb_ddr_wr_packer;
    localparam int          IN_WIDTH        = 32;
    localparam int          OUT_WIDTH       = 256;
    localparam int          BURST_LEN       = 16;
    localparam int          BUF_DEPTH_WIDTH = 6;
    localparam int          ADDR_WIDTH      = 28;
    localparam logic [27:0] BASE_ADDR       = 28'h0;
    localparam int          FRAME_BEATS     = 32;
    localparam int          DEPTH           = 64;
    localparam int          WAIT_LIMIT      = 5000;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  mask;
        logic         last;
    } beat_t;

    typedef struct {
        logic [27:0] addr;
        logic [6:0]  len;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_done;
    logic [6:0] buf_level;

    ddr_wr_packer_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    ddr_wr_packer #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .BURST_LEN(BURST_LEN),
        .BUF_DEPTH_WIDTH(BUF_DEPTH_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .BASE_ADDR(BASE_ADDR), .FRAME_BEATS(FRAME_BEATS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .frame_done(frame_done),
        .buf_level(buf_level)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  drv_data_q[$];
    logic         drv_last_q[$];
    beat_t        exp_beat_q[$];
    cmd_t         exp_cmd_q[$];
    logic [27:0]  obs_cmd_addrs[$];
    logic [31:0]  m_words[$];
    int           m_pend = 0;
    logic [27:0]  m_addr = BASE_ADDR;
    int           m_frame_beats = 0;
    int           exp_frames = 0;
    int           obs_frames = 0;
    bit           valid_rand = 1'b0;
    bit           data_ready_rand = 1'b0;
    bit           cmd_hold = 1'b0;
    bit           stall_prev = 1'b0;
    logic [255:0] stall_data;
    logic [31:0]  stall_mask;
    bit           cmd_open = 1'b0;
    int           obs_beat_idx = 0;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Closes the current group of beats into one burst at the running frame address.
    function automatic void modelEmitBurst();
        cmd_t  c;
        beat_t b;
        c.addr = m_addr;
        c.len  = 7'(m_pend);
        exp_cmd_q.push_back(c);
        b = exp_beat_q.pop_back();
        b.last = 1'b1;
        exp_beat_q.push_back(b);
        m_addr = m_addr + 28'(m_pend * 32);
        m_frame_beats += m_pend;
        if (m_frame_beats >= FRAME_BEATS) begin
            m_addr = BASE_ADDR;
            m_frame_beats = 0;
        end
        m_pend = 0;
    endfunction

    // Frame-level reference: 8 words per beat, zero-padded masked lanes at frame end,
    // 16-beat bursts with the remainder flushed as a short burst.
    function automatic void modelWord(input logic [31:0] w, input logic last);
        beat_t b;
        m_words.push_back(w);
        if (m_words.size() == 8 || last) begin
            b.data = '0;
            b.mask = '0;
            b.last = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (i < m_words.size()) b.data[i*32 +: 32] = m_words[i];
                else                    b.mask[i*4 +: 4]   = 4'hF;
            end
            m_words.delete();
            exp_beat_q.push_back(b);
            m_pend++;
            if (m_pend == BURST_LEN || last) modelEmitBurst();
        end
        if (last) begin
            m_addr = BASE_ADDR;
            m_frame_beats = 0;
            exp_frames++;
        end
    endfunction

    task automatic applyStimulus(input int n, input bit last, input bit seq, input logic [31:0] base);
        logic [31:0] w;
        logic        l;
        for (int i = 0; i < n; i++) begin
            w = seq ? base + 32'(i) : $urandom();
            l = last && (i == n - 1);
            drv_data_q.push_back(w);
            drv_last_q.push_back(l);
            modelWord(w, l);
        end
    endtask

    task automatic waitDrain(input string tag);
        int cyc = 0;
        while (!(drv_data_q.size() == 0 && exp_cmd_q.size() == 0 &&
                 exp_beat_q.size() == m_pend && !bus.wr_data_valid && !bus.wr_cmd_valid)
               && cyc < WAIT_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        checkOutput({tag, "_drained"}, 256'(cyc < WAIT_LIMIT), 256'(1));
        checkOutput({tag, "_frames"}, 256'(obs_frames), 256'(exp_frames));
        checkOutput({tag, "_level"}, 256'(buf_level), 256'(m_pend));
    endtask

    // Word source: offers the queue head, retires it when in_ready shows it will be taken.
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (drv_data_q.size() > 0 && (!valid_rand || $urandom_range(0, 3) != 0)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = drv_data_q[0];
                bus.in_last  = drv_last_q[0];
                if (bus.in_ready) begin
                    void'(drv_data_q.pop_front());
                    void'(drv_last_q.pop_front());
                end
            end else begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
            end
        end
    end

    // Controller model and monitor: drives readies, checks commands, beats and frame pulses.
    initial begin
        cmd_t  c;
        beat_t b;
        bus.wr_cmd_ready  = 1'b0;
        bus.wr_data_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.wr_cmd_ready  = !cmd_hold;
            bus.wr_data_ready = data_ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst_n) begin
                if (frame_done) obs_frames++;
                if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin
                    obs_cmd_addrs.push_back(bus.wr_cmd_addr);
                    checkOutput("cmd_expected", 256'(exp_cmd_q.size() != 0), 256'(1));
                    if (exp_cmd_q.size() != 0) begin
                        c = exp_cmd_q.pop_front();
                        checkOutput("cmd_addr", 256'(bus.wr_cmd_addr), 256'(c.addr));
                        checkOutput("cmd_len", 256'(bus.wr_cmd_len), 256'(c.len));
                    end
                    cmd_open = 1'b1;
                    obs_beat_idx = 0;
                end
                if (bus.wr_data_valid) begin
                    checkOutput("data_after_cmd", 256'(cmd_open), 256'(1));
                    if (stall_prev) begin
                        checkOutput("data_stable", bus.wr_data, stall_data);
                        checkOutput("mask_stable", 256'(bus.wr_data_mask), 256'(stall_mask));
                    end
                    if (bus.wr_data_ready) begin
                        stall_prev = 1'b0;
                        checkOutput("beat_expected", 256'(exp_beat_q.size() != 0), 256'(1));
                        if (exp_beat_q.size() != 0) begin
                            b = exp_beat_q.pop_front();
                            checkOutput("beat_data", bus.wr_data, b.data);
                            checkOutput("beat_mask", 256'(bus.wr_data_mask), 256'(b.mask));
                            checkOutput("beat_last", 256'(bus.wr_data_last), 256'(b.last));
                        end
                        obs_beat_idx++;
                        if (bus.wr_data_last) cmd_open = 1'b0;
                    end else begin
                        stall_prev = 1'b1;
                        stall_data = bus.wr_data;
                        stall_mask = bus.wr_data_mask;
                    end
                end else if (stall_prev) begin
                    checkOutput("valid_held", 256'(bus.wr_data_valid), 256'(1));
                    stall_prev = 1'b0;
                end
            end
        end
    end

    // Run-time bound so a stuck design still reports.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 256'(bus.in_ready), 256'(0));
        checkOutput("rst_cmd_valid", 256'(bus.wr_cmd_valid), 256'(0));
        checkOutput("rst_data_valid", 256'(bus.wr_data_valid), 256'(0));
        checkOutput("rst_level", 256'(buf_level), 256'(0));
        checkOutput("rst_frame_done", 256'(frame_done), 256'(0));
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_release", 256'(bus.in_ready), 256'(1));

        $display("[TB] sequential 128-word stream");
        applyStimulus(128, 1'b0, 1'b1, 32'h0);
        waitDrain("seq128");

        $display("[TB] 131-word frame with flush");
        applyStimulus(131, 1'b1, 1'b0, 32'h0);
        waitDrain("flush131");

        $display("[TB] command backpressure until buffer full");
        cmd_hold = 1'b1;
        applyStimulus(600, 1'b0, 1'b0, 32'h0);
        cyc = 0;
        while (buf_level != 7'(DEPTH) && cyc < WAIT_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("full_level", 256'(buf_level), 256'(DEPTH));
        checkOutput("full_in_ready", 256'(bus.in_ready), 256'(0));
        repeat (20) @(negedge clk);
        checkOutput("held_level", 256'(buf_level), 256'(DEPTH));
        checkOutput("held_cmd_valid", 256'(bus.wr_cmd_valid), 256'(1));
        if (exp_cmd_q.size() != 0)
            checkOutput("held_cmd_addr", 256'(bus.wr_cmd_addr), 256'(exp_cmd_q[0].addr));
        cmd_hold = 1'b0;
        waitDrain("backpressure");

        $display("[TB] random valid and data-ready toggling");
        valid_rand = 1'b1;
        data_ready_rand = 1'b1;
        applyStimulus(300, 1'b1, 1'b0, 32'h0);
        applyStimulus(int'($urandom_range(1, 200)), 1'b1, 1'b0, 32'h0);
        waitDrain("random");
        valid_rand = 1'b0;
        data_ready_rand = 1'b0;

        $display("[TB] frame wrap with 96 beats");
        obs_cmd_addrs.delete();
        applyStimulus(768, 1'b0, 1'b1, 32'h1000);
        waitDrain("wrap");
        checkOutput("wrap_cmd_count", 256'(obs_cmd_addrs.size()), 256'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < obs_cmd_addrs.size())
                checkOutput($sformatf("wrap_addr%0d", i), 256'(obs_cmd_addrs[i]),
                            256'((i % 2 == 1) ? 28'h200 : 28'h0));
        end

        $display("[TB] reset during data beat 5");
        applyStimulus(200, 1'b0, 1'b0, 32'h0);
        cyc = 0;
        while (!(bus.wr_data_valid && obs_beat_idx >= 5) && cyc < WAIT_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reached_beat5", 256'(cyc < WAIT_LIMIT), 256'(1));
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        drv_data_q.delete();
        drv_last_q.delete();
        #1;
        checkOutput("mid_rst_cmd_valid", 256'(bus.wr_cmd_valid), 256'(0));
        checkOutput("mid_rst_data_valid", 256'(bus.wr_data_valid), 256'(0));
        checkOutput("mid_rst_data", bus.wr_data, 256'(0));
        checkOutput("mid_rst_mask", 256'(bus.wr_data_mask), 256'(0));
        checkOutput("mid_rst_last", 256'(bus.wr_data_last), 256'(0));
        checkOutput("mid_rst_level", 256'(buf_level), 256'(0));
        checkOutput("mid_rst_in_ready", 256'(bus.in_ready), 256'(0));
        checkOutput("mid_rst_cmd_addr", 256'(bus.wr_cmd_addr), 256'(0));
        exp_beat_q.delete();
        exp_cmd_q.delete();
        m_words.delete();
        m_pend = 0;
        m_addr = BASE_ADDR;
        m_frame_beats = 0;
        stall_prev = 1'b0;
        cmd_open = 1'b0;
        obs_beat_idx = 0;
        obs_cmd_addrs.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(67, 1'b1, 1'b1, 32'hA000);
        waitDrain("after_reset");
        checkOutput("after_reset_cmd_count", 256'(obs_cmd_addrs.size()), 256'(1));
        if (obs_cmd_addrs.size() != 0)
            checkOutput("after_reset_addr", 256'(obs_cmd_addrs[0]), 256'(BASE_ADDR));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
